// File: rtl/srb_pkg.sv
// srb_pkg
//   Shared definitions for the serial register bridge: command byte field
//   positions, the bridge and transmit-handshake state encodings, and the
//   helper that turns a register byte count into a slice width.
package srb_pkg;

    // Command byte layout: [7] valid, [6] write(1)/read(0), [5:0] address.
    localparam int CMD_VALID_BIT = 7;
    localparam int CMD_WR_BIT    = 6;
    localparam int CMD_ADDR_W    = 6;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_BYTE   = 4'd1,
        WR_COMMIT = 4'd2,
        RD_LOAD   = 4'd3,
        RD_SEND   = 4'd4,
        RD_WAIT   = 4'd5,
        ST_POP    = 4'd6,
        ST_CAP    = 4'd7,
        ST_SEND   = 4'd8
    } srb_state_e;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_START  = 2'd1,
        TX_IGNORE = 2'd2,
        TX_WAIT   = 2'd3
    } srb_tx_state_e;

    // Width in bits of one register slice.
    function automatic int srb_slice_w(input int reg_bytes);
        return reg_bytes * 8;
    endfunction

endpackage

// File: rtl/srb_tx_byte.sv
// srb_tx_byte
//   One-byte transmit handshake shared by register reads and FIFO streaming.
//   While req_i is high and the transmitter is idle, data_i is latched and
//   tx_start pulses for one cycle with tx_data stable. The cycle after the
//   pulse ignores tx_busy (the transmitter may not have raised it yet), then
//   the engine waits for tx_busy low and pulses done_o.
// Ports
//   ftdi_clk  in   clock
//   reset     in   asynchronous, active-high
//   req_i     in   a byte is waiting to be sent (level)
//   data_i    in   byte to send, sampled on launch
//   tx_busy   in   transmitter busy
//   tx_data   out  byte presented to the transmitter
//   tx_start  out  1-cycle launch pulse
//   done_o    out  1-cycle pulse: byte fully transmitted
module srb_tx_byte
    import srb_pkg::*;
(
    input  logic       ftdi_clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic [7:0] data_i,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       done_o
);

    srb_tx_state_e state_q, state_d;
    logic [7:0]    data_q;
    logic          launch;

    assign launch = (state_q == TX_IDLE) && req_i && !tx_busy;

    always_ff @(posedge ftdi_clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (launch) begin
                data_q <= data_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:   if (launch) state_d = TX_START;
            TX_START:  state_d = TX_IGNORE;
            TX_IGNORE: state_d = TX_WAIT;
            TX_WAIT:   if (!tx_busy) state_d = TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_data  = data_q;
        tx_start = (state_q == TX_START);
        done_o   = (state_q == TX_WAIT) && !tx_busy;
    end

endmodule

// File: rtl/serial_reg_bridge.sv
// serial_reg_bridge
//   Byte-stream host bridge: UART command bytes become atomic accesses to a
//   bank of NUM_REGS registers of REG_BYTES bytes (LSB first), and a read of
//   STREAM_ADDR streams up to MAX_BURST bytes from a sample FIFO.
//   Optional feature macro: SRB_RX_TIMEOUT_EN -- when defined, a write that
//   stalls for TIMEOUT_CYCLES cycles between bytes is discarded and
//   timeout_o pulses; when undefined, writes wait forever and timeout_o is 0.
// Ports
//   ftdi_clk    in   clock
//   reset       in   asynchronous, active-high
//   rx_data     in   received byte
//   rx_valid    in   1-cycle pulse, rx_data valid
//   tx_data     out  byte to transmit, stable while tx_start=1
//   tx_start    out  1-cycle transmit launch
//   tx_busy     in   transmitter busy
//   reg_q       out  flat register values, reg n at [n*W +: W]
//   reg_wstb    out  1-cycle pulse on bit n when reg n is updated
//   reg_rd_i    in   read-only/status sources, same layout as reg_q
//   fifo_empty  in   sample FIFO empty
//   fifo_data   in   FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  1-cycle FIFO pop
//   timeout_o   out  1-cycle pulse on an aborted write
module serial_reg_bridge
    import srb_pkg::*;
#(
    parameter int          NUM_REGS       = 16,
    parameter int          REG_BYTES      = 4,
    parameter logic [63:0] RO_MASK        = 64'h0000_0000_0000_0004,
    parameter int          STREAM_ADDR    = 3,
    parameter int          MAX_BURST      = 4096,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                            ftdi_clk,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [7:0]                      tx_data,
    output logic                            tx_start,
    input  logic                            tx_busy,
    output logic [NUM_REGS*REG_BYTES*8-1:0] reg_q,
    output logic [NUM_REGS-1:0]             reg_wstb,
    input  logic [NUM_REGS*REG_BYTES*8-1:0] reg_rd_i,
    input  logic                            fifo_empty,
    input  logic [7:0]                      fifo_data,
    output logic                            fifo_rd_en,
    output logic                            timeout_o
);

    localparam int W     = srb_slice_w(REG_BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    srb_state_e            state_q, state_d;
    logic [CMD_ADDR_W-1:0] addr_q;
    logic [1:0]            byte_cnt_q;
    logic [W-1:0]          shadow_q;
    logic [W-1:0]          shift_q;
    logic [CNT_W-1:0]      burst_cnt_q;
    logic [7:0]            cap_q;

    logic [IDX_W-1:0] addr_idx;
    logic             addr_in_range;
    logic             addr_ro;
    logic             wr_allowed;
    logic             last_byte;
    logic             pop_ok;
    logic             rx_cmd;
    logic             commit_en;
    logic             timeout_hit;
    logic [W-1:0]     rd_src;

    logic             tx_req;
    logic [7:0]       tx_byte;
    logic             tx_done;

    assign addr_idx      = addr_q[IDX_W-1:0];
    assign addr_in_range = ({1'b0, addr_q} < 7'(NUM_REGS));
    assign addr_ro       = RO_MASK[addr_q];
    // The stream address is never backed by a writable register.
    assign wr_allowed    = addr_in_range && !addr_ro
                           && (addr_q != CMD_ADDR_W'(STREAM_ADDR));
    assign last_byte     = (byte_cnt_q == 2'(REG_BYTES - 1));
    assign pop_ok        = !fifo_empty && (burst_cnt_q < CNT_W'(MAX_BURST));
    assign rx_cmd        = rx_valid && rx_data[CMD_VALID_BIT];

    // Read source: unmapped addresses read as zero so the host still gets
    // a full register's worth of bytes.
    always_comb begin
        rd_src = '0;
        if (addr_in_range) begin
            if (addr_ro) begin
                rd_src = reg_rd_i[int'(addr_idx)*W +: W];
            end else begin
                rd_src = reg_q[int'(addr_idx)*W +: W];
            end
        end
    end

`ifdef SRB_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a byte.
    assign timeout_hit = (state_q == WR_BYTE) && !rx_valid
                         && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ftdi_clk or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if ((state_q != WR_BYTE) || rx_valid || timeout_hit) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // State register
    always_ff @(posedge ftdi_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_cmd) begin
                    if (rx_data[CMD_WR_BIT]) begin
                        state_d = WR_BYTE;
                    end else if (rx_data[CMD_ADDR_W-1:0] == CMD_ADDR_W'(STREAM_ADDR)) begin
                        state_d = ST_POP;
                    end else begin
                        state_d = RD_LOAD;
                    end
                end
            end
            WR_BYTE: begin
                if (rx_valid && last_byte) begin
                    state_d = WR_COMMIT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WR_COMMIT: state_d = IDLE;
            RD_LOAD:   state_d = RD_SEND;
            RD_SEND:   if (tx_start) state_d = RD_WAIT;
            RD_WAIT:   if (tx_done) state_d = last_byte ? IDLE : RD_SEND;
            ST_POP:    state_d = pop_ok ? ST_CAP : IDLE;
            ST_CAP:    state_d = ST_SEND;
            ST_SEND:   if (tx_done) state_d = ST_POP;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fifo_rd_en = (state_q == ST_POP) && pop_ok;
        tx_req     = (state_q == RD_SEND) || (state_q == ST_SEND);
        tx_byte    = (state_q == ST_SEND) ? cap_q : shift_q[7:0];
        commit_en  = (state_q == WR_COMMIT) && wr_allowed;
    end

    // Command datapath: address, byte counter, write shadow, read snapshot,
    // burst counter and stream capture.
    always_ff @(posedge ftdi_clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            byte_cnt_q  <= '0;
            shadow_q    <= '0;
            shift_q     <= '0;
            burst_cnt_q <= '0;
            cap_q       <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_cmd) begin
                        addr_q      <= rx_data[CMD_ADDR_W-1:0];
                        byte_cnt_q  <= '0;
                        burst_cnt_q <= '0;
                    end
                end
                WR_BYTE: begin
                    if (rx_valid) begin
                        shadow_q[8*byte_cnt_q +: 8] <= rx_data;
                        byte_cnt_q                  <= byte_cnt_q + 1'b1;
                    end else if (timeout_hit) begin
                        shadow_q <= '0;
                    end
                end
                RD_LOAD: begin
                    shift_q    <= rd_src;
                    byte_cnt_q <= '0;
                end
                RD_WAIT: begin
                    if (tx_done) begin
                        shift_q    <= shift_q >> 8;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                ST_POP: begin
                    if (fifo_rd_en && (burst_cnt_q != '1)) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                end
                ST_CAP: cap_q <= fifo_data;
                default: ;
            endcase
        end
    end

    // Register bank: each register updates and strobes together, so the
    // strobe is seen in the same cycle as the new value.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [W-1:0] val_q;
        logic         stb_q;
        logic         hit;

        assign hit = commit_en && (addr_idx == IDX_W'(gi));

        always_ff @(posedge ftdi_clk or posedge reset) begin
            if (reset) begin
                val_q <= '0;
                stb_q <= 1'b0;
            end else begin
                stb_q <= hit;
                if (hit) begin
                    val_q <= shadow_q;
                end
            end
        end

        assign reg_q[gi*W +: W] = val_q;
        assign reg_wstb[gi]     = stb_q;
    end

    srb_tx_byte u_tx (
        .ftdi_clk (ftdi_clk),
        .reset    (reset),
        .req_i    (tx_req),
        .data_i   (tx_byte),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .done_o   (tx_done)
    );

endmodule

// File: tb/tb_serial_reg_bridge.sv
module tb_serial_reg_bridge;

    localparam int NUM_REGS  = 16;
    localparam int REG_BYTES = 4;
    localparam int W         = 32;

    logic                  ftdi_clk = 1'b0;
    logic                  reset;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic [NUM_REGS*W-1:0] reg_q;
    logic [NUM_REGS-1:0]   reg_wstb;
    logic [NUM_REGS*W-1:0] reg_rd_i;
    logic                  fifo_empty;
    logic [7:0]            fifo_data = 8'h00;
    logic                  fifo_rd_en;
    logic                  timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } wstb_t;

    logic [7:0] exp_tx_q[$];
    wstb_t      exp_wstb_q[$];

    // Transmitter model: busy for 3 cycles starting the cycle after tx_start.
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);

    // FIFO model: k-th popped byte overall is k[7:0].
    int   fifo_count = 0;
    int   fifo_seq   = 0;
    logic fifo_load;
    int   fifo_load_val;
    assign fifo_empty = (fifo_count == 0);

    always #5 ftdi_clk = ~ftdi_clk;

    serial_reg_bridge #(
        .NUM_REGS       (NUM_REGS),
        .REG_BYTES      (REG_BYTES),
        .RO_MASK        (64'h4),
        .STREAM_ADDR    (3),
        .MAX_BURST      (4096),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .ftdi_clk   (ftdi_clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .reg_q      (reg_q),
        .reg_wstb   (reg_wstb),
        .reg_rd_i   (reg_rd_i),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .timeout_o  (timeout_o)
    );

    always @(posedge ftdi_clk) begin
        if (reset) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(posedge ftdi_clk) begin
        if (fifo_load) begin
            fifo_count <= fifo_load_val;
        end else if (fifo_rd_en && fifo_count > 0) begin
            fifo_data  <= 8'(fifo_seq);
            fifo_seq   <= fifo_seq + 1;
            fifo_count <= fifo_count - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge ftdi_clk) begin
        logic [7:0] e;
        wstb_t      w;
        if (!reset) begin
            if (tx_start) begin
                check("tx_start_while_busy", 64'(tx_busy), 64'd0);
                if (exp_tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, expected no byte", tx_data);
                end else begin
                    e = exp_tx_q.pop_front();
                    check("tx_byte", 64'(tx_data), 64'(e));
                    $display("tx byte 0x%02h (expected 0x%02h)", tx_data, e);
                end
            end
            if (reg_wstb != '0) begin
                if (exp_wstb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wstb_unexpected: got strobe 0x%04h, expected none", reg_wstb);
                end else begin
                    w = exp_wstb_q.pop_front();
                    check("wstb_bits", 64'(reg_wstb), 64'(16'd1 << w.idx));
                    check("wstb_value", 64'(reg_q[w.idx*W +: W]), 64'(w.val));
                    $display("write strobe reg %0d value 0x%08h", w.idx, reg_q[w.idx*W +: W]);
                end
            end
            if (fifo_rd_en) begin
                check("fifo_pop_when_empty", 64'(fifo_empty), 64'd0);
            end
`ifndef SRB_RX_TIMEOUT_EN
            if (timeout_o) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_unexpected: got timeout_o=1, expected 0");
            end
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge ftdi_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge ftdi_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge ftdi_clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while ((exp_tx_q.size() != 0 || exp_wstb_q.size() != 0) && i < budget) begin
            @(negedge ftdi_clk);
            i++;
        end
        n_checks++;
        if (exp_tx_q.size() != 0 || exp_wstb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d tx bytes and %0d strobes outstanding after %0d cycles, expected 0",
                     name, exp_tx_q.size(), exp_wstb_q.size(), i);
            exp_tx_q.delete();
            exp_wstb_q.delete();
        end
        idle(20);
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [31:0] v, input bit strobe);
        wstb_t w;
        if (strobe) begin
            w.idx = int'(a);
            w.val = v;
            exp_wstb_q.push_back(w);
        end
        send_byte({2'b11, a});
        for (int k = 0; k < REG_BYTES; k++) begin
            idle(2);
            send_byte(v[8*k +: 8]);
        end
        drain("write", 50);
    endtask

    task automatic read_reg(input logic [5:0] a, input logic [31:0] v);
        for (int k = 0; k < REG_BYTES; k++) exp_tx_q.push_back(v[8*k +: 8]);
        send_byte({2'b10, a});
        drain("read", 200);
    endtask

    task automatic load_fifo(input int n);
        @(negedge ftdi_clk);
        fifo_load_val = n;
        fifo_load     = 1'b1;
        @(negedge ftdi_clk);
        fifo_load     = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        reg_rd_i      = '0;
        fifo_load     = 1'b0;
        fifo_load_val = 0;
        idle(4);
        reset = 1'b0;
        idle(2);

        // Reset state
        check("reset_reg_q", 64'(|reg_q), 64'd0);
        check("reset_wstb", 64'(reg_wstb), 64'd0);
        check("reset_tx_start", 64'(tx_start), 64'd0);
        check("reset_tx_data", 64'(tx_data), 64'd0);
        check("reset_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        check("reset_timeout", 64'(timeout_o), 64'd0);

        // Write reg 0, then read it back
        write_reg(6'd0, 32'h4433_2211, 1'b1);
        check("reg0_after_write", 64'(reg_q[0*W +: W]), 64'h4433_2211);
        read_reg(6'd0, 32'h4433_2211);

        // Read-only reg 2: value changes after the snapshot
        reg_rd_i[2*W +: W] = 32'hA1B2_C3D4;
        exp_tx_q.push_back(8'hD4);
        exp_tx_q.push_back(8'hC3);
        exp_tx_q.push_back(8'hB2);
        exp_tx_q.push_back(8'hA1);
        send_byte(8'h82);
        idle(3);
        reg_rd_i[2*W +: W] = 32'h5566_7788;
        drain("read_ro", 200);

        // Writes to a read-only address and to the stream address are dropped
        write_reg(6'd2, 32'hDEAD_BEEF, 1'b0);
        check("reg2_unchanged", 64'(reg_q[2*W +: W]), 64'd0);
        write_reg(6'd3, 32'h1234_5678, 1'b0);
        check("reg3_unchanged", 64'(reg_q[3*W +: W]), 64'd0);

        // Unmapped address reads as zeros
        read_reg(6'd63, 32'h0000_0000);

        // Another register, last address, and a non-command byte in IDLE
        write_reg(6'd5, 32'hCAFE_0107, 1'b1);
        write_reg(6'd15, 32'h8000_00FF, 1'b1);
        send_byte(8'h45);
        idle(3);
        read_reg(6'd5, 32'hCAFE_0107);
        read_reg(6'd15, 32'h8000_00FF);
        check("reg0_kept", 64'(reg_q[0*W +: W]), 64'h4433_2211);

        // Stream of 5 bytes
        load_fifo(5);
        for (int k = 0; k < 5; k++) exp_tx_q.push_back(8'(k));
        send_byte(8'h83);
        drain("stream5", 400);
        check("stream5_fifo_left", 64'(fifo_count), 64'd0);

        // Stream with the FIFO already empty: no bytes
        send_byte(8'h83);
        idle(10);
        check("stream_empty_fifo_left", 64'(fifo_count), 64'd0);

        // Stream bounded by MAX_BURST
        load_fifo(5000);
        for (int k = 5; k < 5 + 4096; k++) exp_tx_q.push_back(8'(k));
        send_byte(8'h83);
        drain("stream_burst", 60000);
        check("stream_burst_fifo_left", 64'(fifo_count), 64'd904);

        // Bridge returns to normal register reads after streaming
        read_reg(6'd0, 32'h4433_2211);

`ifdef SRB_RX_TIMEOUT_EN
        begin
            int  cyc;
            bit  seen;
            send_byte(8'hC1);
            idle(2);
            send_byte(8'hAA);
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 200) begin
                @(negedge ftdi_clk);
                cyc++;
                if (timeout_o) seen = 1'b1;
            end
            check("timeout_cycle", 64'(cyc), 64'd100);
            idle(1);
            check("timeout_pulse_width", 64'(timeout_o), 64'd0);
            check("reg1_after_timeout", 64'(reg_q[1*W +: W]), 64'd0);
            write_reg(6'd1, 32'h0102_0304, 1'b1);
            check("reg1_after_rewrite", 64'(reg_q[1*W +: W]), 64'h0102_0304);
        end
`endif

        check("scoreboard_empty", 64'(exp_tx_q.size() + exp_wstb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
